// File: rtl/display_pkg.sv
// Shared constants for the seven-segment text display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    localparam int DIGITS    = 4;
    localparam int MSG_DEPTH = 16;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/seg_text_scanner_if.sv
// Message-write and display-drive bundle for the text scanner.
// The master side loads text and paces refresh; the slave side drives the digits.
interface seg_text_scanner_if #(
    parameter int DIGITS = 4,
    parameter int AW     = 4
) ();

    logic              refresh_clk;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic [AW:0]       msg_len;
    logic              scroll_en;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;

    modport master (
        output refresh_clk,
        output wr_en,
        output wr_addr,
        output wr_data,
        output msg_len,
        output scroll_en,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  refresh_clk,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  msg_len,
        input  scroll_en,
        output an,
        output seg,
        output dp
    );

endinterface

// File: rtl/ascii_to_seg.sv
// ASCII to active-low seven-segment glyph; letters are case-insensitive.
// Anything without a sensible glyph is blank.
module ascii_to_seg
    import display_pkg::*;
(
    input  logic [7:0] ch,
    output logic [6:0] seg
);

    logic [7:0] up;

    always_comb begin
        up = ch;
        if (ch >= "a" && ch <= "z") begin
            up = ch & 8'hDF;
        end
    end

    always_comb begin
        seg = SEG_BLANK;
        case (up)
            "0": seg = SEG_0;
            "1": seg = SEG_1;
            "2": seg = 7'b0100100;
            "3": seg = 7'b0110000;
            "4": seg = 7'b0011001;
            "5": seg = 7'b0010010;
            "6": seg = 7'b0000010;
            "7": seg = 7'b1111000;
            "8": seg = SEG_8;
            "9": seg = 7'b0010000;
            "-": seg = SEG_DASH;
            "A": seg = SEG_A;
            "B": seg = 7'b0000011;
            "C": seg = 7'b1000110;
            "D": seg = 7'b0100001;
            "E": seg = 7'b0000110;
            "F": seg = 7'b0001110;
            "G": seg = 7'b1000010;
            "H": seg = 7'b0001001;
            "I": seg = 7'b1111001;
            "J": seg = 7'b1100001;
            "K": seg = 7'b0001010;
            "L": seg = 7'b1000111;
            "M": seg = 7'b1101010;
            "N": seg = 7'b0101011;
            "O": seg = 7'b1000000;
            "P": seg = 7'b0001100;
            "Q": seg = 7'b0011000;
            "R": seg = 7'b0101111;
            "S": seg = 7'b0010010;
            "T": seg = 7'b0000111;
            "U": seg = 7'b1000001;
            "V": seg = 7'b1100011;
            "W": seg = 7'b1010101;
            "X": seg = 7'b0001001;
            "Y": seg = 7'b0010001;
            "Z": seg = 7'b0100100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_text_scanner.sv
// Multiplexed seven-segment text driver with optional horizontal scroll.
// refresh_clk is a level from the divider; only its rising edge is used.
module seg_text_scanner #(
    parameter int DIGITS       = display_pkg::DIGITS,
    parameter int MSG_DEPTH    = display_pkg::MSG_DEPTH,
    parameter int SCROLL_TICKS = 5000
) (
    input logic               clk,
    input logic               reset,
    seg_text_scanner_if.slave bus
);

    import display_pkg::*;

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(SCROLL_TICKS - 1);
    localparam logic [AW:0]   DEPTH      = (AW + 1)'(MSG_DEPTH);

    logic              prev;
    logic              tick;
    logic [DW-1:0]     digit_sel;
    logic [DW-1:0]     digit_nxt;
    logic [AW-1:0]     offset;
    logic [CW-1:0]     scroll_cnt;
    logic [AW-1:0]     rd_addr;
    logic [AW:0]       len_clamped;
    logic [7:0]        buffer [MSG_DEPTH];
    logic [7:0]        rd_char;
    logic [6:0]        glyph;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    // Address and glyph are looked up for the digit about to be lit.
    always_comb begin
        tick        = bus.refresh_clk & ~prev;
        digit_nxt   = (digit_sel == LAST_DIGIT) ? '0 : digit_sel + 1'b1;
        rd_addr     = offset + AW'(DIGITS - 1 - int'(digit_nxt));
        len_clamped = (bus.msg_len > DEPTH) ? DEPTH : bus.msg_len;
        rd_char     = buffer[rd_addr];
        seg_nxt     = ({1'b0, rd_addr} < len_clamped) ? glyph : SEG_BLANK;
        an_nxt      = ~(DIGITS'(1) << digit_nxt);
    end

    ascii_to_seg u_dec (
        .ch  (rd_char),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= 1'b1;
            digit_sel <= LAST_DIGIT;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            prev <= bus.refresh_clk;
            if (tick) begin
                digit_sel <= digit_nxt;
                an_q      <= an_nxt;
                seg_q     <= seg_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.scroll_en) begin
            scroll_cnt <= '0;
            offset     <= '0;
        end else if (tick) begin
            if (scroll_cnt == LAST_CNT) begin
                scroll_cnt <= '0;
                offset     <= offset + 1'b1;
            end else begin
                scroll_cnt <= scroll_cnt + 1'b1;
            end
        end
    end

    // Display reads see the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buffer[i] <= ASCII_SPACE;
            end
        end else if (bus.wr_en) begin
            buffer[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg_text_scanner.sv
// Scoreboard bench for seg_text_scanner: stimulus queues expected digits,
// a monitor pops and compares one cycle after each refresh edge.
module tb_seg_text_scanner;

    localparam int DIG = 4;
    localparam int AW  = 4;
    localparam int ST  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seg_text_scanner_if #(.DIGITS(DIG), .AW(AW)) bus ();

    seg_text_scanner #(
        .DIGITS       (DIG),
        .MSG_DEPTH    (16),
        .SCROLL_TICKS (ST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q [$];
    logic        mprev = 1'b1;

    logic [6:0] hexseg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [7:0] hexch [16] = '{
        "0", "1", "2", "3", "4", "5", "6", "7",
        "8", "9", "A", "B", "C", "D", "E", "F"
    };

    int         m_dsel;
    int         m_off;
    int         m_cnt;
    int         m_len;
    bit         m_scroll;
    logic [6:0] m_buf [16];

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0],
                     expv[11:8], expv[7:1], expv[0]);
        end
    endtask

    initial begin
        logic t;
        logic [11:0] e;
        forever begin
            @(posedge clk);
            if (reset) begin
                mprev = 1'b1;
            end else begin
                t     = bus.refresh_clk & ~mprev;
                mprev = bus.refresh_clk;
                if (t) begin
                    #1;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_refresh: got an=%b seg=%b, want none",
                                 bus.an, bus.seg);
                    end else begin
                        e = exp_q.pop_front();
                        chk("refresh", {bus.an, bus.seg, bus.dp}, e);
                    end
                end
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [6:0] s);
        exp_q.push_back({a, s, 1'b1});
    endtask

    task automatic pulse();
        @(negedge clk);
        bus.refresh_clk = 1'b1;
        @(negedge clk);
        bus.refresh_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic dir_tick(input logic [3:0] a, input logic [6:0] s);
        push(a, s);
        pulse();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic model_tick();
        int addr;
        logic [6:0] s;
        m_dsel = (m_dsel + 1) % DIG;
        addr   = (m_off + DIG - 1 - m_dsel) & 15;
        s      = (addr < m_len) ? m_buf[addr] : 7'h7F;
        push(~(4'b0001 << m_dsel), s);
        if (m_scroll) begin
            if (m_cnt == ST - 1) begin
                m_cnt = 0;
                m_off = (m_off + 1) % 16;
            end else begin
                m_cnt++;
            end
        end
        pulse();
    endtask

    initial begin
        bus.refresh_clk = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.msg_len     = '0;
        bus.scroll_en   = 1'b0;

        // reset with refresh_clk already high
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
        repeat (3) @(negedge clk);
        chk("no_tick_high", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
        bus.refresh_clk = 1'b0;
        dir_tick(4'b1110, 7'h7F);
        dir_tick(4'b1101, 7'h7F);
        repeat (5) @(negedge clk);
        chk("hold", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'h7F, 1'b1});

        // static "01A-"
        wr(4'd0, "0");
        wr(4'd1, "1");
        wr(4'd2, "A");
        wr(4'd3, "-");
        bus.msg_len = 5'd4;
        dir_tick(4'b1011, 7'b1111001);
        dir_tick(4'b0111, 7'b1000000);
        dir_tick(4'b1110, 7'b0111111);
        dir_tick(4'b1101, 7'b0001000);
        dir_tick(4'b1011, 7'b1111001);
        dir_tick(4'b0111, 7'b1000000);

        // "8888" with msg_len=2; outputs hold until the next tick
        wr(4'd0, "8");
        wr(4'd1, "8");
        wr(4'd2, "8");
        wr(4'd3, "8");
        bus.msg_len = 5'd2;
        repeat (2) @(negedge clk);
        chk("hold_on_write", {bus.an, bus.seg, bus.dp}, {4'b0111, 7'b1000000, 1'b1});
        dir_tick(4'b1110, 7'h7F);
        dir_tick(4'b1101, 7'h7F);
        dir_tick(4'b1011, 7'b0000000);
        dir_tick(4'b0111, 7'b0000000);

        // msg_len=0 blanks everything but keeps scanning
        bus.msg_len = 5'd0;
        dir_tick(4'b1110, 7'h7F);
        dir_tick(4'b1101, 7'h7F);

        // write and refresh of address 1 in the same cycle
        bus.msg_len = 5'd4;
        @(negedge clk);
        push(4'b1011, 7'b0000000);
        bus.refresh_clk = 1'b1;
        bus.wr_en       = 1'b1;
        bus.wr_addr     = 4'd1;
        bus.wr_data     = "1";
        @(negedge clk);
        bus.refresh_clk = 1'b0;
        bus.wr_en       = 1'b0;
        @(negedge clk);
        dir_tick(4'b0111, 7'b0000000);
        dir_tick(4'b1110, 7'b0000000);
        dir_tick(4'b1101, 7'b0000000);
        dir_tick(4'b1011, 7'b1111001);

        // scroll through 16 distinct glyphs; msg_len 31 clamps to 16
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), hexch[i]);
            m_buf[i] = hexseg[i];
        end
        m_dsel   = 2;
        m_off    = 0;
        m_cnt    = 0;
        m_len    = 16;
        m_scroll = 1'b1;
        bus.msg_len   = 5'd31;
        @(negedge clk);
        bus.scroll_en = 1'b1;
        for (int k = 0; k < 84; k++) begin
            model_tick();
        end

        // reset mid-scan at offset 5
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
        m_dsel = 3;
        m_off  = 0;
        m_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            m_buf[i] = 7'h7F;
        end
        wr(4'd3, "1");
        m_buf[3] = 7'b1111001;
        wr(4'd8, "8");
        m_buf[8] = 7'b0000000;
        for (int k = 0; k < 6; k++) begin
            model_tick();
        end

        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_refresh: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_text_scanner.md
# seg_text_scanner

Multiplexed seven-segment text driver that sits directly downstream of `clock_divider`. It stores a short ASCII message in a register buffer and decodes characters to segment patterns. Each rising edge of the divider's `divided_clk` lights the next digit. An optional fixed-rate horizontal scroll steps through the message. All logic runs on the board `clk`; the divider output is treated as a level input and edge-detected, never used as a clock.

## Interface
- `DIGITS`, 4: number of physical digits / anode lines.
- `MSG_DEPTH`, 16: message buffer entries; must be a power of two (address width `AW` = log2, 4 by default).
- `SCROLL_TICKS`, 5000: refresh ticks per scroll step (0.5 s with the 10 kHz refresh).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `refresh_clk` in 1: `divided_clk` from `clock_divider`; same clock domain, no synchronizer.
- `wr_en` in 1: write strobe for the message buffer.
- `wr_addr` in AW: buffer index.
- `wr_data` in 8: ASCII character.
- `msg_len` in AW+1: number of valid characters. Values above `MSG_DEPTH` clamp to `MSG_DEPTH`.
- `scroll_en` in 1: 1 = scroll, 0 = static window at offset 0.
- `an` out DIGITS: anodes, active-low, one-hot-low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low; constant 1.

## Operation
- Tick generation:
  - `prev` holds `refresh_clk` from the previous cycle.
  - `tick` = `refresh_clk & ~prev`.
  - `prev` resets to 1, so a `refresh_clk` that is already high out of reset does not produce a tick.
- Digit select: `digit_sel` ranges 0..DIGITS-1 and increments by one per tick, wrapping DIGITS-1 → 0. Reset value is DIGITS-1, so the first tick lights digit 0.
- Character index:
  - `an[d]` shows buffer address `(offset + DIGITS-1-d) mod MSG_DEPTH`, using natural AW-bit wrap.
  - `an[DIGITS-1]` is the leftmost digit.
  - If the address is ≥ clamped `msg_len`, the digit is blank. The positions past `msg_len` therefore form the gap between scroll repeats.
- Scroll:
  - When `scroll_en`=1, `scroll_cnt` counts ticks. On a tick with `scroll_cnt == SCROLL_TICKS-1`, `scroll_cnt` returns to 0 and `offset` increments mod `MSG_DEPTH`.
  - When `scroll_en`=0, `scroll_cnt` and `offset` are held at 0, cleared synchronously on the first cycle it is low.
- Buffer writes:
  - When `wr_en`=1, `buffer[wr_addr]` ← `wr_data` at the clk edge, independent of `tick`.
  - Reset fills every entry with 0x20 (space).
  - A write and a display read of the same address in the same cycle: the display shows the old value. The new value appears on that digit's next refresh.
- Decode (`ascii_to_seg`):
  - '0'..'9' map to standard glyphs; 'A'..'Z' and 'a'..'z' map case-insensitively to best-effort glyphs; '-' lights g only.
  - Space and every unsupported code are blank (7'h7F).
  - Required codes: '0'=7'b1000000, '1'=7'b1111001, '8'=7'b0000000, 'A'=7'b0001000, '-'=7'b0111111.
- `msg_len`=0: all digits blank; anodes keep scanning.

## Timing
- Reset values: `an`=all ones, `seg`=7'h7F, `dp`=1, `digit_sel`=DIGITS-1, `offset`=0, `scroll_cnt`=0, `prev`=1.
- Latency: if `tick` is true in cycle T, `an` and `seg` are registered and change together at the end of T, valid from cycle T+1. There is no cycle where `an` and `seg` disagree.
- Between ticks, `an` and `seg` hold. They do not track buffer or `msg_len` changes until the next tick.
- Offset change and display update in the same tick: the digit loaded on that tick uses the pre-increment `offset`. The new offset applies from the next tick.
- Reset asserted mid-scan: on the next clk edge all state returns to reset values, regardless of `tick`.
- With the default divider: a tick every 10000 clk, a full 4-digit scan every 40000 clk (2.5 kHz frame rate), a scroll step every 5000 ticks.

## Structure
- Shared package `display_pkg`:
  - constants `DIGITS`, `MSG_DEPTH`, `SEG_BLANK`=7'h7F, `ASCII_SPACE`=8'h20;
  - named segment constants for the required glyphs.
- Sub-module `ascii_to_seg`: combinational, 8-bit ASCII in, 7-bit active-low pattern out. It is instantiated once, on the selected character.
- Top level holds the edge detector, `digit_sel`, the scroll counter/offset, the buffer and the output registers.

## Test plan
- Reset with `refresh_clk` held high, then two rising edges of `refresh_clk` → no tick until the first true 0→1 edge. After edge 1, `an`=4'b1110; after edge 2, `an`=4'b1101. `seg`=7'h7F throughout (buffer is all spaces).
- Write "01A-" to addresses 0..3, `msg_len`=4, `scroll_en`=0, scan 4 ticks:
  - `an`=4'b0111 → `seg`=7'b1000000
  - `an`=4'b1011 → `seg`=7'b1111001
  - `an`=4'b1101 → `seg`=7'b0001000
  - `an`=4'b1110 → `seg`=7'b0111111
- `msg_len`=2 with "8888" written: only `an[3]` and `an[2]` show 7'b0000000; the other two digits show 7'h7F.
- `SCROLL_TICKS`=4, `msg_len`=16, `scroll_en`=1: `offset` reaches 15 after 60 ticks and wraps to 0 after 64 ticks. The leftmost digit at `offset` 15 shows address 15; the next digit to its right shows address 0.
- Write and refresh of the same address in the same cycle: old glyph shown on this tick, new glyph exactly DIGITS ticks later.
- `reset` pulsed between ticks with `scroll_en`=1 and `offset`=5 → the cycle after, `an`=4'hF, `seg`=7'h7F, `offset`=0, buffer all spaces.
